instr_loader: RTL and testbench
===============================

# instr_loader

Program loader that writes LC2K machine words into the instruction memory's write port from a byte stream, then releases the CPU. Sits between an external byte source (UART receiver or testbench) and instruction memory. Holds the CPU in reset until a complete program has been written. Parses a 2-byte word-count header followed by 4-byte big-endian instruction words.

## Interface

- ADDR_W, 8, instruction memory address width; capacity is 2**ADDR_W words.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- in_valid  in  1  byte source has a byte on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; transfer occurs when in_valid & in_ready.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  write data.
- word_count  out  ADDR_W+1  words written in the current load.
- busy  out  1  load in progress.
- done  out  1  last load completed successfully.
- error  out  1  last load aborted because the header count exceeded capacity.
- cpu_hold  out  1  CPU reset request; 1 until a load completes.

## Operation

- States: IDLE, HDR_HI, HDR_LO, DATA, WRITE, DONE, ERR. Outputs are decoded from registered state.
- IDLE: in_ready=0. start=1 -> HDR_HI. Clear word_count, word pointer, byte index and count register.
- HDR_HI: in_ready=1. On accept, count[15:8]=in_data -> HDR_LO.
- HDR_LO: in_ready=1. On accept, form N={count[15:8], in_data}:
  - N==0 -> DONE.
  - N>2**ADDR_W -> ERR.
  - Otherwise -> DATA with byte index 0.
- DATA: in_ready=1. Each accepted byte shifts into a 32-bit register, MSB first: shreg={shreg[23:0], in_data}. The 4th accepted byte -> WRITE.
- WRITE: in_ready=0, mem_we=1, mem_addr=word pointer, mem_wdata=shreg.
  - Word pointer and word_count increment at the clock edge ending WRITE.
  - If word_count+1==N -> DONE; else -> DATA, byte index 0.
- DONE: done=1, cpu_hold=0, in_ready=0. start=1 -> HDR_HI (reload), which clears done and sets cpu_hold=1.
- ERR: error=1, cpu_hold=1, in_ready=0. start=1 -> HDR_HI, which clears error.
- busy=1 in HDR_HI, HDR_LO, DATA and WRITE.
- start is ignored while busy.
- Bytes presented while in_ready=0 are not consumed; the source holds them.
- N==2**ADDR_W is legal. The final write is to address 2**ADDR_W-1, and word_count ends at 2**ADDR_W, so word_count needs its extra bit.

## Timing

- Reset (async, rst_n low): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, word_count=0, busy=0, done=0, error=0, cpu_hold=1.
- Reset mid-load aborts immediately. Words already written stay in memory; the loader returns to IDLE with cpu_hold=1.
- Latency from start: HDR_HI is active the cycle after start is sampled.
- mem_we asserts in the cycle after the 4th byte of a word is accepted, for exactly 1 cycle.
- Minimum 5 cycles per word (4 byte accepts + 1 WRITE). Minimum total load time is 3 + 5N cycles from start to DONE.
- done/cpu_hold change in the cycle after the final WRITE. For N==0 they change the cycle after the 2nd header byte.
- in_valid gaps of any length in HDR_*/DATA stall the FSM with no state change.

## Test plan

- Reset: hold rst_n=0 with random inputs -> every output at its listed reset value, cpu_hold=1, in_ready=0.
- Two-word load: start, then bytes 00 02 00 81 00 0A 00 82 00 09 with in_valid=1 continuously.
  - Required: mem_we pulses: addr 0 data 0x0081000A, then addr 1 data 0x00820009, 5 cycles apart.
  - Required: word_count=2, done=1, cpu_hold=0 at cycle 13 after start.
- Zero count: start, bytes 00 00 -> DONE the next cycle, no mem_we, word_count=0, cpu_hold=0.
- Overflow (ADDR_W=8): header 01 01 (N=257) -> error=1, cpu_hold=1, no mem_we.
  - Then start + 00 01 + 01 C0 00 00 -> write addr 0 data 0x01C00000, done=1, error=0.
- Stalls: same two-word stream with in_valid toggled pseudo-randomly -> identical mem writes and final state; no byte is dropped or duplicated, including a byte held across WRITE.
- Reset mid-load: after word 0 plus 2 bytes of word 1, pulse rst_n low -> reset values, no further mem_we. A subsequent full load completes normally.

Source files
------------

// File: rtl/instr_loader.sv
// LC2K program loader: parses a 16-bit word-count header and big-endian
// 32-bit words from a byte stream into instruction memory, then frees the CPU.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_HI,
    S_HDR_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [16:0] CAP = 17'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   wc_q, wc_d;

  logic        acc;
  logic [15:0] n_hdr;
  logic [15:0] wc_ext;

  assign acc    = in_valid & in_ready;
  assign wc_ext = 16'(wc_q) + 16'd1;

  // State and datapath registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      bidx_q  <= '0;
      wptr_q  <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      bidx_q  <= bidx_d;
      wptr_q  <= wptr_d;
      wc_q    <= wc_d;
    end
  end

  // Next-state: header parse, byte assembly and per-word write sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    bidx_d  = bidx_q;
    wptr_d  = wptr_q;
    wc_d    = wc_q;
    n_hdr   = {cnt_q[15:8], in_data};
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR_HI;
          cnt_d   = '0;
          shreg_d = '0;
          bidx_d  = '0;
          wptr_d  = '0;
          wc_d    = '0;
        end
      end
      S_HDR_HI: begin
        if (acc) begin
          cnt_d   = {in_data, 8'h00};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (acc) begin
          cnt_d  = n_hdr;
          bidx_d = '0;
          if (n_hdr == 16'd0) begin
            state_d = S_DONE;
          end else if ({1'b0, n_hdr} > CAP) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          shreg_d = {shreg_q[23:0], in_data};
          bidx_d  = bidx_q + 2'd1;
          if (bidx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        wptr_d  = wptr_q + ADDR_W'(1);
        wc_d    = wc_q + (ADDR_W + 1)'(1);
        bidx_d  = '0;
        state_d = (wc_ext == cnt_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    in_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    word_count = wc_q;
    unique case (state_q)
      S_HDR_HI, S_HDR_LO, S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      S_WRITE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wptr_q;
        mem_wdata = shreg_q;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      S_ERR: error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomised bench for instr_loader: byte-count reference model checked every
// cycle, plus literal expectations for the directed load scenarios.
module tb_instr_loader;

  localparam int AW  = 8;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic          error;
  logic          cpu_hold;

  instr_loader #(.ADDR_W(AW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .word_count(word_count),
    .busy(busy),
    .done(done),
    .error(error),
    .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edges  = 0;
  int t0     = 0;
  int pct    = 100;

  logic [7:0]  q[$];
  logic [31:0] prog[$];

  // model: mode 0 idle, 1 loading, 2 done, 3 error
  int         m_mode;
  int         m_k;
  int         m_n;
  int         m_wc;
  bit         m_wp;
  logic [7:0] m_hi;
  logic [7:0] m_data[$];

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          t;
  } wr_t;
  wr_t wlog[$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)",
               nm, act, exp, edges);
    end
  endtask

  function automatic logic [31:0] exp_word(input int w);
    return {m_data[4*w], m_data[4*w+1], m_data[4*w+2], m_data[4*w+3]};
  endfunction

  task automatic model_reset();
    m_mode = 0;
    m_k    = 0;
    m_n    = 0;
    m_wc   = 0;
    m_wp   = 0;
    m_data.delete();
  endtask

  // one clock edge of the loader seen as a byte/word counter
  task automatic model_update();
    if (m_mode != 1) begin
      if (start) begin
        m_mode = 1;
        m_k    = 0;
        m_n    = 0;
        m_wc   = 0;
        m_wp   = 0;
        m_data.delete();
        t0     = edges - 1;
      end
    end else if (m_wp) begin
      m_wp = 0;
      m_wc++;
      if (m_wc == m_n) m_mode = 2;
    end else if (in_valid) begin
      if (m_k == 0) begin
        m_hi = in_data;
      end else if (m_k == 1) begin
        m_n = int'({m_hi, in_data});
        if (m_n == 0) m_mode = 2;
        else if (m_n > CAP) m_mode = 3;
      end else begin
        m_data.push_back(in_data);
        if ((m_k - 2) % 4 == 3) m_wp = 1;
      end
      m_k++;
    end
  endtask

  task automatic check_outputs();
    bit ld;
    ld = (m_mode == 1);
    chk("in_ready", in_ready, ld && !m_wp);
    chk("mem_we", mem_we, ld && m_wp);
    chk("busy", busy, ld);
    chk("done", done, m_mode == 2);
    chk("error", error, m_mode == 3);
    chk("cpu_hold", cpu_hold, m_mode != 2);
    chk("word_count", word_count, m_wc);
    if (ld && m_wp) begin
      chk("mem_addr", mem_addr, m_wc);
      chk("mem_wdata", mem_wdata, exp_word(m_wc));
    end
    if (mem_we === 1'b1)
      wlog.push_back('{int'(mem_addr), mem_wdata, edges - t0});
  endtask

  bit acc_s;

  task automatic sample();
    @(negedge clk);
    check_outputs();
    acc_s = (in_valid === 1'b1) && (in_ready === 1'b1);
  endtask

  task automatic advance();
    @(posedge clk);
    edges++;
    if (rst_n) model_update();
    if (acc_s && q.size() > 0) void'(q.pop_front());
    #1;
    start = 0;
    if (m_mode == 1 && m_k != 1 && !m_wp && $urandom_range(0, 19) == 0)
      start = 1;
    in_valid = (q.size() > 0) && ($urandom_range(1, 100) <= pct);
    in_data  = (q.size() > 0) ? q[0] : 8'($urandom);
  endtask

  task automatic kick();
    wlog.delete();
    start    = 1;
    in_valid = (q.size() > 0);
    in_data  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  // ends at a negedge with final outputs checked; caller then advances
  task automatic run_load(input int budget);
    int n;
    n = 0;
    kick();
    do begin
      sample();
      advance();
      n++;
    end while (m_mode == 1 && n < budget);
    chk("load_timeout", m_mode == 1, 0);
    sample();
  endtask

  task automatic two_word();
    q = '{8'h00, 8'h02, 8'h00, 8'h81, 8'h00, 8'h0A,
          8'h00, 8'h82, 8'h00, 8'h09};
  endtask

  task automatic rand_prog(input int n);
    logic [31:0] w;
    prog.delete();
    q.delete();
    q.push_back(8'(n >> 8));
    q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      prog.push_back(w);
      for (int b = 3; b >= 0; b--) q.push_back(w[8*b +: 8]);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 0;
    start    = 0;
    in_valid = 0;
    in_data  = 0;
    model_reset();

    // reset with random inputs
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      sample();
      chk("rst_cpu_hold", cpu_hold, 1);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
    end
    @(posedge clk);
    #1;
    start    = 0;
    in_valid = 0;
    rst_n    = 1;
    repeat (2) begin
      sample();
      advance();
    end

    // two-word load, continuous stream
    pct = 100;
    two_word();
    run_load(100);
    chk("tw_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("tw_addr0", wlog[0].addr, 0);
      chk("tw_data0", wlog[0].data, 32'h0081000A);
      chk("tw_t0", wlog[0].t, 7);
      chk("tw_addr1", wlog[1].addr, 1);
      chk("tw_data1", wlog[1].data, 32'h00820009);
      chk("tw_gap", wlog[1].t - wlog[0].t, 5);
    end
    chk("tw_done_cycle", edges - t0, 13);
    chk("tw_wc", word_count, 2);
    chk("tw_done", done, 1);
    chk("tw_hold", cpu_hold, 0);
    advance();

    // zero count
    q = '{8'h00, 8'h00};
    run_load(50);
    chk("z_cycle", edges - t0, 3);
    chk("z_nwrites", wlog.size(), 0);
    chk("z_wc", word_count, 0);
    chk("z_done", done, 1);
    chk("z_hold", cpu_hold, 0);
    advance();

    // overflow header, then recovery
    q = '{8'h01, 8'h01};
    run_load(50);
    chk("ov_error", error, 1);
    chk("ov_hold", cpu_hold, 1);
    chk("ov_nwrites", wlog.size(), 0);
    advance();
    q = '{8'h00, 8'h01, 8'h01, 8'hC0, 8'h00, 8'h00};
    run_load(50);
    chk("ov2_nwrites", wlog.size(), 1);
    if (wlog.size() == 1) begin
      chk("ov2_addr", wlog[0].addr, 0);
      chk("ov2_data", wlog[0].data, 32'h01C00000);
    end
    chk("ov2_done", done, 1);
    chk("ov2_error", error, 0);
    advance();

    // same two-word stream with random stalls
    pct = 40;
    two_word();
    run_load(500);
    chk("st_nwrites", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("st_data0", wlog[0].data, 32'h0081000A);
      chk("st_data1", wlog[1].data, 32'h00820009);
      chk("st_addr1", wlog[1].addr, 1);
    end
    chk("st_wc", word_count, 2);
    chk("st_done", done, 1);
    advance();

    // reset after word 0 plus two bytes of word 1
    pct = 100;
    two_word();
    kick();
    n = 0;
    do begin
      sample();
      advance();
      n++;
    end while (m_k < 8 && n < 100);
    chk("mr_reached", m_k, 8);
    rst_n    = 0;
    model_reset();
    q.delete();
    start    = 0;
    in_valid = 0;
    wlog.delete();
    repeat (3) begin
      sample();
      advance();
    end
    chk("mr_nwrites", wlog.size(), 0);
    chk("mr_hold", cpu_hold, 1);
    chk("mr_wc", word_count, 0);
    rst_n = 1;
    repeat (2) begin
      sample();
      advance();
    end

    // random programs with random stalls
    pct = 70;
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 12);
      rand_prog(n);
      run_load(2000);
      chk("rp_nwrites", wlog.size(), n);
      for (int i = 0; i < wlog.size() && i < n; i++) begin
        chk("rp_addr", wlog[i].addr, i);
        chk("rp_data", wlog[i].data, prog[i]);
      end
      chk("rp_wc", word_count, n);
      advance();
    end

    // full capacity load
    pct = 100;
    rand_prog(CAP);
    run_load(3000);
    chk("cap_nwrites", wlog.size(), CAP);
    if (wlog.size() == CAP) begin
      chk("cap_last_addr", wlog[CAP-1].addr, CAP - 1);
      chk("cap_last_data", wlog[CAP-1].data, prog[CAP-1]);
    end
    chk("cap_wc", word_count, CAP);
    chk("cap_done", done, 1);
    chk("cap_cycle", edges - t0, 3 + 5 * CAP);
    advance();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
